// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state encoding, opcode constants and width defaults
package proc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;

endpackage

// File: rtl/dmem_watchdog.sv
// rtl/dmem_watchdog.sv - counts cycles a memory request waits for ack; flags expiry
module dmem_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires on the LIMIT-th waiting cycle so the request stays up exactly LIMIT cycles.
    assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - LW/SW memory stage with req/ack data port; DMEM_TIMEOUT_EN adds a request watchdog
module memory_access
    import proc_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [3:0]        rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write,
    output logic [3:0]        wb_rd,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;
    logic [3:0]        rd_q, rd_d;
    logic              req_q, req_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [3:0]        wb_rd_q, wb_rd_d;
    logic              err_q, err_d;

    logic accept;
    logic is_mem;
    logic timeout_hit;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_read || mem_write;

`ifdef DMEM_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    // Counter sits cleared while idle, so it starts from zero on every entry to ACCESS.
    assign wd_clr = (state_q != ACCESS);
    assign wd_en  = (state_q == ACCESS) && !dmem_ack;

    dmem_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        mem_to_reg_d   = mem_to_reg_q;
        reg_write_d    = reg_write_q;
        rd_d           = rd_q;
        req_d          = req_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        err_d          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = DATA_W'(alu_result);
                        wb_reg_write_d = reg_write;
                        wb_rd_d        = rd;
                    end else if (alu_result[0]) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = DATA_W'(alu_result);
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = rd;
                        err_d          = 1'b1;
                    end else begin
                        addr_d       = alu_result;
                        wdata_d      = write_data;
                        we_d         = mem_write;
                        mem_to_reg_d = mem_to_reg;
                        reg_write_d  = reg_write;
                        rd_d         = rd;
                        req_d        = 1'b1;
                        state_d      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked before timeout so a coincident ack completes normally.
                if (req_q && dmem_ack) begin
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = mem_to_reg_q ? dmem_rdata : DATA_W'(addr_q);
                    wb_reg_write_d = reg_write_q && !we_q;
                    wb_rd_d        = rd_q;
                    state_d        = IDLE;
                end else if (timeout_hit) begin
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = DATA_W'(addr_q);
                    wb_reg_write_d = 1'b0;
                    wb_rd_d        = rd_q;
                    err_d          = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            reg_write_q    <= 1'b0;
            rd_q           <= '0;
            req_q          <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            mem_to_reg_q   <= mem_to_reg_d;
            reg_write_q    <= reg_write_d;
            rd_q           <= rd_d;
            req_q          <= req_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            err_q          <= err_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign err          = err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [3:0]  rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_reg_write;
    logic [3:0]  wb_rd;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .rd           (rd),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] wd,
                         input logic mr, input logic mw, input logic m2r,
                         input logic rw, input logic [3:0] r);
        in_valid   = v;
        alu_result = a;
        write_data = wd;
        mem_read   = mr;
        mem_write  = mw;
        mem_to_reg = m2r;
        reg_write  = rw;
        rd         = r;
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);
        tick();
        tick();

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rw", wb_reg_write, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // back-to-back ADDs
        drive(1, 16'h0005, 16'h0, 0, 0, 0, 1, 4'd3);
        tick();
        chk("add0_valid", wb_valid, 1);
        chk("add0_data", wb_data, 16'h0005);
        chk("add0_rd", wb_rd, 3);
        chk("add0_rw", wb_reg_write, 1);
        chk("add0_ready", in_ready, 1);
        chk("add0_err", err, 0);
        drive(1, 16'h0006, 16'h0, 0, 0, 0, 1, 4'd4);
        tick();
        chk("add1_valid", wb_valid, 1);
        chk("add1_data", wb_data, 16'h0006);
        chk("add1_rd", wb_rd, 4);
        chk("add1_ready", in_ready, 1);
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        tick();
        chk("add_pulse", wb_valid, 0);
        chk("add_hold_data", wb_data, 16'h0006);
        chk("add_hold_rd", wb_rd, 4);

        // LW with ack in third request cycle
        drive(1, 16'h0010, 16'h0, 1, 0, 1, 1, 4'd2);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk("lw_req", dmem_req, 1);
            chk("lw_ready", in_ready, 0);
            chk("lw_addr", dmem_addr, 16'h0010);
            chk("lw_we", dmem_we, 0);
            chk("lw_no_wb", wb_valid, 0);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 16'hBEEF;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        chk("lw_wb_valid", wb_valid, 1);
        chk("lw_wb_data", wb_data, 16'hBEEF);
        chk("lw_wb_rw", wb_reg_write, 1);
        chk("lw_wb_rd", wb_rd, 2);
        chk("lw_req_drop", dmem_req, 0);
        chk("lw_ready_back", in_ready, 1);

        // SW acked in first request cycle
        drive(1, 16'h0020, 16'h1234, 0, 1, 0, 0, 4'd5);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        chk("sw_req", dmem_req, 1);
        chk("sw_we", dmem_we, 1);
        chk("sw_wdata", dmem_wdata, 16'h1234);
        chk("sw_addr", dmem_addr, 16'h0020);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_wb_rw", wb_reg_write, 0);
        chk("sw_wb_data", wb_data, 16'h0020);
        chk("sw_req_drop", dmem_req, 0);

        // stray ack while idle is ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 0);

        // misaligned LW
        drive(1, 16'h0011, 16'h0, 1, 0, 1, 1, 4'd7);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        chk("mis_req", dmem_req, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_err", err, 1);
        chk("mis_rw", wb_reg_write, 0);
        chk("mis_ready", in_ready, 1);
        tick();
        chk("mis_err_pulse", err, 0);
        chk("mis_wb_pulse", wb_valid, 0);

        // read+write together: write wins
        drive(1, 16'h0040, 16'hA5A5, 1, 1, 1, 1, 4'd6);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        chk("rw_we", dmem_we, 1);
        chk("rw_wdata", dmem_wdata, 16'hA5A5);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h1111;
        tick();
        dmem_ack   = 1'b0;
        chk("rw_wb_rw", wb_reg_write, 0);
        chk("rw_wb_valid", wb_valid, 1);

        // reset mid-access, then a late ack
        drive(1, 16'h0030, 16'h0, 1, 0, 1, 1, 4'd9);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        chk("mid_req", dmem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_addr", dmem_addr, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h5555;
        tick();
        dmem_ack   = 1'b0;
        chk("late_ack_wb", wb_valid, 0);
        chk("late_ack_data", wb_data, 0);

`ifdef DMEM_TIMEOUT_EN
        // timeout with no ack
        drive(1, 16'h0050, 16'h0, 1, 0, 1, 1, 4'd1);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", dmem_req, 1);
            chk("to_ready", in_ready, 0);
            tick();
        end
        chk("to_req_drop", dmem_req, 0);
        chk("to_err", err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_rw", wb_reg_write, 0);
        chk("to_ready_back", in_ready, 1);

        // ack coincident with timeout completes normally
        drive(1, 16'h0060, 16'h0, 1, 0, 1, 1, 4'd8);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        tick();
        tick();
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hCAFE;
        tick();
        dmem_ack   = 1'b0;
        chk("to_race_err", err, 0);
        chk("to_race_data", wb_data, 16'hCAFE);
        chk("to_race_rw", wb_reg_write, 1);
`else
        // without the watchdog the request waits as long as needed
        drive(1, 16'h0050, 16'h0, 1, 0, 1, 1, 4'd1);
        tick();
        drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("wait_req_high", dmem_req, 1);
        chk("wait_no_err", err, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hCAFE;
        tick();
        dmem_ack   = 1'b0;
        chk("wait_wb_data", wb_data, 16'hCAFE);
        chk("wait_wb_rd", wb_rd, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
